// File: rtl/mux_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// Imported by the interface, the picker and the arbiter top.
package mux_arb_pkg;

    localparam int REQ_N = 4;
    localparam int SEL_W = $clog2(REQ_N);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TURN
    } arb_state_t;

    function automatic logic [REQ_N-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_arbiter4_if.sv
// Requester-side bundle of the shared mux resource.
// master = requester/mux side, slave = arbiter.
interface mux_arbiter4_if;
    import mux_arb_pkg::*;

    logic [REQ_N-1:0] req;
    logic [REQ_N-1:0] done;
    logic [REQ_N-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             preempt;

    modport master (
        output req, done,
        input  grant, sel, busy, preempt
    );

    modport slave (
        input  req, done,
        output grant, sel, busy, preempt
    );

endinterface

// File: rtl/mux_arbiter4_rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ...
// modulo 4. Kept standalone so wider-select arbiters can reuse it.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        // Scan from the farthest offset back towards ptr so the nearest hit wins.
        for (int k = REQ_N - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin owner of a shared 4:1 mux path: one-hot grant, registered select,
// bounded hold with preemption and a one-cycle dead turnaround between owners.
module mux_arbiter4
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic           clk,
    input logic           rst_n,
    mux_arbiter4_if.slave bus
);

    localparam int                HOLD_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = (MAX_HOLD < 1) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam bit                PREEMPT_EN = (MAX_HOLD > 0);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REQ_N-1:0]  grant_q;
    logic [SEL_W-1:0]  sel_q;
    logic              busy_q;
    logic              preempt_q;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic              release_now;
    logic              others_pend;
    logic              preempt_now;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // sel_q is the owner index while granted; grant_q masks the owner out.
    assign release_now = bus.done[sel_q] | ~bus.req[sel_q];
    assign others_pend = |(bus.req & ~grant_q);
    assign preempt_now = PREEMPT_EN && (hold_cnt == HOLD_LAST) && others_pend;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state)
                ARB_IDLE, ARB_TURN: begin
                    if (pick_any) begin
                        state    <= ARB_GRANT;
                        grant_q  <= onehot(pick_idx);
                        sel_q    <= pick_idx;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state    <= ARB_IDLE;
                    end
                end
                ARB_GRANT: begin
                    if (release_now || preempt_now) begin
                        state     <= ARB_TURN;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        ptr       <= sel_q + SEL_W'(1);
                        // A voluntary release in the same cycle is not a preemption.
                        preempt_q <= ~release_now;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt  <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux_arbiter4.sv
// Directed bench for mux_arbiter4 (MAX_HOLD=4): per-cycle vector table plus
// hand-written reset sequences.
module tb_mux_arbiter4;
    import mux_arb_pkg::*;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] exp_grant;
        logic [1:0] exp_sel;
        logic       exp_busy;
        logic       exp_preempt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    mux_arbiter4_if bus ();

    mux_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic p);
        check({tag, " grant"}, 32'(bus.grant), 32'(g));
        check({tag, " sel"}, 32'(bus.sel), 32'(s));
        check({tag, " busy"}, 32'(bus.busy), 32'(b));
        check({tag, " preempt"}, 32'(bus.preempt), 32'(p));
    endtask

    function automatic void add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                                input logic [1:0] s, input logic b, input logic p);
        vec_t v;
        v.req = r; v.done = d; v.exp_grant = g; v.exp_sel = s; v.exp_busy = b; v.exp_preempt = p;
        vecs.push_back(v);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 4'b0000;

        // From reset (ptr=0): 1010 -> owner 1, release, turn, owner 3
        add(4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b1010, 4'b0010, 4'b0000, 2'd1, 0, 0);
        add(4'b1010, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd3, 0, 0);
        // All requesting, each owner releases after 2 cycles: order 0,1,2,3,0
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 4'b0010, 4'b0000, 2'd1, 0, 0);
        add(4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 4'b0100, 4'b0000, 2'd2, 0, 0);
        add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 4'b1000, 4'b0000, 2'd3, 0, 0);
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Non-owner done bits ignored while 1 owns
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b0010, 4'b1000, 4'b0010, 2'd1, 1, 0);
        add(4'b0010, 4'b0001, 4'b0010, 2'd1, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0);
        // Requester 2 never releases, req[0] pending: grant[2] exactly 4 cycles
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b0101, 4'b0000, 4'b0000, 2'd2, 0, 1);
        add(4'b0101, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Release coinciding with the preempt condition is a plain release
        add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1001, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1001, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1001, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1001, 4'b1000, 4'b0000, 2'd3, 0, 0);
        add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Hold counter saturates alone; a late competitor preempts on the next edge
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b0011, 4'b0000, 4'b0000, 2'd1, 0, 1);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 2'd0, 0, 0);
        rst_n = 1'b1;

        // Idle for 10 cycles with no requests
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_outs($sformatf("idle%0d", i), 4'b0000, 2'd0, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            bus.req  = vecs[i].req;
            bus.done = vecs[i].done;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_sel,
                       vecs[i].exp_busy, vecs[i].exp_preempt);
        end

        // Async reset mid-grant, then arbitration restarts from ptr=0
        bus.req  = 4'b0100;
        bus.done = 4'b0000;
        @(posedge clk);
        #1;
        check_outs("pre_rst", 4'b0100, 2'd2, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'b0000, 2'd0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("in_rst", 4'b0000, 2'd0, 0, 0);
        bus.req = 4'b1010;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_rst", 4'b0010, 2'd1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter4.md
# mux_arbiter4

Round-robin arbiter sharing one 4:1 datapath resource (a 2-bit-select mux path such as `Multiplex2bit`) among four requesters. It grants exactly one requester at a time and drives the mux select `sel` to that requester's index. A grant is held until the owner releases it, or until it is preempted after a bounded hold time. A one-cycle dead turnaround separates consecutive owners.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant is held while other requests pend; 0 disables preemption.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  request per requester; held high while access is wanted.
- `done`  in  4  release pulse per requester; only the current owner's bit is honoured.
- `grant`  out  4  one-hot grant; all-zero when nobody owns the resource.
- `sel`  out  2  index of current owner; holds last owner's index when idle; feeds the mux select.
- `busy`  out  1  high while any grant bit is high.
- `preempt`  out  1  one-cycle pulse in the cycle a grant is forcibly revoked.

## Operation
- States: ARB_IDLE, ARB_GRANT, ARB_TURN.
- Round-robin pointer `ptr` (2 bits): winner = first set `req` bit scanning `ptr`, `ptr+1`, … modulo 4.
- ARB_IDLE: if `req != 0`, go to ARB_GRANT with winner `w`. Set `grant[w]`, `sel=w`, `busy=1`, `hold_cnt=0`.
- ARB_GRANT release: occurs when `done[w]` is 1 or `req[w]` is 0. Go to ARB_TURN, `grant=0`, `busy=0`, `ptr=w+1` (wraps 3→0).
- ARB_GRANT preemption: when `MAX_HOLD!=0`, `hold_cnt==MAX_HOLD-1`, and any `req` bit other than `w` is set. Same transition as release, plus `preempt=1` for that cycle.
- ARB_GRANT otherwise: stay; `hold_cnt` increments and saturates at `MAX_HOLD-1`. Its width is `$clog2(MAX_HOLD+1)` (min 1).
- Simultaneous release and preempt condition: treated as release; `preempt` stays 0.
- ARB_TURN: lasts exactly one cycle with `grant=0`. It arbitrates like ARB_IDLE and goes directly to ARB_GRANT if `req != 0`, else to ARB_IDLE.
- `done` bits of non-owners are ignored. `done` while in ARB_IDLE/ARB_TURN is ignored.
- A preempted requester keeps `req` high and re-competes; the pointer already favours the others.
- `sel` never changes while `grant` is non-zero.

## Timing
- All outputs are registered.
- Reset values: state ARB_IDLE, `grant=0`, `sel=0`, `busy=0`, `preempt=0`, `ptr=0`, `hold_cnt=0`.
- Asserting `rst_n` low mid-grant drops `grant`/`busy` immediately (async). Arbitration restarts from `ptr=0` after release.
- Latency from ARB_IDLE: `req` sampled high at edge N → `grant`/`sel` valid after edge N.
- Handover: owner release sampled at edge N → `grant=0` after N. Next owner granted after N+1.
- Preemption: owner holds `grant` for exactly `MAX_HOLD` cycles, then ARB_TURN.
- `req` must be stable around the clock edge. No combinational path exists from `req`/`done` to any output.

## Structure
- Package `mux_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t`
  - `localparam int REQ_N = 4`
- Sub-module `rr_pick4`: combinational; takes `req[3:0]` and `ptr[1:0]`, returns `any` and `idx[1:0]`. It is reused by future wider-select arbiters.
- Top level holds the FSM, pointer, hold counter, and output registers.

## Test plan
- Reset, then `req=4'b0000` for 10 cycles → `grant=0`, `sel=0`, `busy=0` throughout.
- `req=4'b1010` from reset → `grant=4'b0010`, `sel=1`. After `done[1]`: one cycle of `grant=0`, then `grant=4'b1000`, `sel=3`.
- `req=4'b1111` held, each owner pulsing `done` after 2 cycles → grant order 0,1,2,3,0. Exactly one zero-grant cycle between owners.
- `MAX_HOLD=4`, requester 2 never releases, `req[0]` raised → `grant[2]` high exactly 4 cycles, `preempt` pulses once, then `grant=4'b0001`.
- `done[3]` pulsed while requester 1 owns → no change. `rst_n` low mid-grant → `grant` clears asynchronously and the next winner is the lowest index.
